// File: rtl/mo_pkg.sv
// Shared constants for the matrix-operation memory server: MO opcodes,
// host load targets and server state encoding.
package mo_pkg;

    typedef logic [9:0] idx_t;

    localparam logic [2:0] OP_GET_N   = 3'b000;
    localparam logic [2:0] OP_GET_R   = 3'b001;
    localparam logic [2:0] OP_READ_A  = 3'b010;
    localparam logic [2:0] OP_READ_X  = 3'b011;
    localparam logic [2:0] OP_READ_B  = 3'b100;
    localparam logic [2:0] OP_WRITE_Y = 3'b101;

    localparam logic [1:0] LD_A    = 2'b00;
    localparam logic [1:0] LD_X    = 2'b01;
    localparam logic [1:0] LD_B    = 2'b10;
    localparam logic [1:0] LD_DIMS = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mo_mem_server_if.sv
// Host-load, readback and MO-facing signal bundle of mo_mem_server.
// run_cycles exists only when MO_SRV_CYCLE_CNT_EN is defined.
interface mo_mem_server_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [1:0]  ld_sel;
    logic [9:0]  ld_row;
    logic [9:0]  ld_col;
    logic [9:0]  ld_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  rd_row;
    logic [9:0]  rd_col;
    logic [19:0] rd_data;
    logic        mo_reset;
    logic [2:0]  mo_opcode;
    logic [9:0]  mo_i;
    logic [9:0]  mo_j;
    logic [19:0] mo_out_data;
    logic        mo_fin;
    logic [9:0]  mo_in_data;
`ifdef MO_SRV_CYCLE_CNT_EN
    logic [19:0] run_cycles;
`endif

    modport master (
        output ld_valid, ld_sel, ld_row, ld_col, ld_data, start, rd_row, rd_col,
               mo_opcode, mo_i, mo_j, mo_out_data, mo_fin,
        input  ld_ready, busy, done, err, rd_data, mo_reset, mo_in_data
`ifdef MO_SRV_CYCLE_CNT_EN
        , input run_cycles
`endif
    );

    modport slave (
        input  ld_valid, ld_sel, ld_row, ld_col, ld_data, start, rd_row, rd_col,
               mo_opcode, mo_i, mo_j, mo_out_data, mo_fin,
        output ld_ready, busy, done, err, rd_data, mo_reset, mo_in_data
`ifdef MO_SRV_CYCLE_CNT_EN
        , output run_cycles
`endif
    );

endinterface

// File: rtl/mo_mat_ram.sv
// ROWS x COLS register array: synchronous write, combinational read,
// out-of-range flags for both ports. Out-of-range writes are dropped.
module mo_mat_ram #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [9:0]       wr_row_i,
    input  logic [9:0]       wr_col_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [9:0]       rd_row_i,
    input  logic [9:0]       rd_col_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             wr_oob_o,
    output logic             rd_oob_o
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [9:0] ROWS_W = 10'(ROWS);
    localparam logic [9:0] COLS_W = 10'(COLS);

    logic [WIDTH-1:0] mem_q [ROWS][COLS];

    assign wr_oob_o = (wr_row_i >= ROWS_W) || (wr_col_i >= COLS_W);
    assign rd_oob_o = (rd_row_i >= ROWS_W) || (rd_col_i >= COLS_W);

    // NOTE: storage has no reset; contents are defined only once written.
    always_ff @(posedge clk) begin
        if (we_i && !wr_oob_o)
            mem_q[wr_row_i[RW-1:0]][wr_col_i[CW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = rd_oob_o ? '0 : mem_q[rd_row_i[RW-1:0]][rd_col_i[CW-1:0]];

endmodule

// File: rtl/mo_mem_server.sv
// Memory server for the MO engine: holds n, r, A, X, B, answers MO requests
// combinationally and captures Y. Optional run counter: MO_SRV_CYCLE_CNT_EN.
module mo_mem_server
    import mo_pkg::*;
#(
    parameter int MAX_N = 8,
    parameter int MAX_R = 8
) (
    input logic            clk,
    input logic            reset,
    mo_mem_server_if.slave bus
);
    localparam logic [9:0] MAX_N_W = 10'(MAX_N);
    localparam logic [9:0] MAX_R_W = 10'(MAX_R);

    logic [1:0]  state_q, state_d;
    idx_t        n_q, n_d, r_q, r_d;
    logic        err_q, err_d;
    logic [19:0] rd_data_q;
    idx_t        tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
    logic        tgt_vld_q, tgt_vld_d;

    logic        serving, ld_ready, ld_acc, start_ok, start_bad, dims_bad;
    logic        read_b, write_y, y_we;
    logic [9:0]  a_rd, x_rd, b_rd, resp;
    logic [19:0] y_rd;
    logic        a_woob, x_woob, b_woob, y_woob;
    logic        a_roob, x_roob, b_roob, unused_y_roob;
    logic        rsp_oob, ld_oob;

    assign serving   = (state_q == ST_SERVE);
    assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign ld_acc    = bus.ld_valid && ld_ready;
    assign start_ok  = (state_q == ST_IDLE) && bus.start && (n_q != '0) && (r_q != '0);
    assign start_bad = (state_q == ST_IDLE) && bus.start && ((n_q == '0) || (r_q == '0));
    assign dims_bad  = (bus.ld_row == '0) || (bus.ld_col == '0) ||
                       (bus.ld_row > MAX_N_W) || (bus.ld_col > MAX_R_W);
    assign read_b    = serving && (bus.mo_opcode == OP_READ_B);
    assign write_y   = serving && (bus.mo_opcode == OP_WRITE_Y);
    assign y_we      = write_y && tgt_vld_q;
    assign ld_oob    = ld_acc && (((bus.ld_sel == LD_A) && a_woob) ||
                                  ((bus.ld_sel == LD_X) && x_woob) ||
                                  ((bus.ld_sel == LD_B) && b_woob));

    mo_mat_ram #(.ROWS(MAX_N), .COLS(MAX_R), .WIDTH(10)) u_a (
        .clk(clk), .we_i(ld_acc && (bus.ld_sel == LD_A)),
        .wr_row_i(bus.ld_row), .wr_col_i(bus.ld_col), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.mo_i), .rd_col_i(bus.mo_j), .rd_data_o(a_rd),
        .wr_oob_o(a_woob), .rd_oob_o(a_roob)
    );

    mo_mat_ram #(.ROWS(MAX_R), .COLS(MAX_N), .WIDTH(10)) u_x (
        .clk(clk), .we_i(ld_acc && (bus.ld_sel == LD_X)),
        .wr_row_i(bus.ld_row), .wr_col_i(bus.ld_col), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.mo_i), .rd_col_i(bus.mo_j), .rd_data_o(x_rd),
        .wr_oob_o(x_woob), .rd_oob_o(x_roob)
    );

    mo_mat_ram #(.ROWS(MAX_N), .COLS(MAX_N), .WIDTH(10)) u_b (
        .clk(clk), .we_i(ld_acc && (bus.ld_sel == LD_B)),
        .wr_row_i(bus.ld_row), .wr_col_i(bus.ld_col), .wr_data_i(bus.ld_data),
        .rd_row_i(bus.mo_i), .rd_col_i(bus.mo_j), .rd_data_o(b_rd),
        .wr_oob_o(b_woob), .rd_oob_o(b_roob)
    );

    mo_mat_ram #(.ROWS(MAX_N), .COLS(MAX_N), .WIDTH(20)) u_y (
        .clk(clk), .we_i(y_we),
        .wr_row_i(tgt_row_q), .wr_col_i(tgt_col_q), .wr_data_i(bus.mo_out_data),
        .rd_row_i(bus.rd_row), .rd_col_i(bus.rd_col), .rd_data_o(y_rd),
        .wr_oob_o(y_woob), .rd_oob_o(unused_y_roob)
    );

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        resp    = '0;
        rsp_oob = 1'b0;
        if (serving) begin
            case (bus.mo_opcode)
                OP_GET_N:  resp = n_q;
                OP_GET_R:  resp = r_q;
                OP_READ_A: begin resp = a_rd; rsp_oob = a_roob; end
                OP_READ_X: begin resp = x_rd; rsp_oob = x_roob; end
                OP_READ_B: begin resp = b_rd; rsp_oob = b_roob; end
                default:   resp = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        r_d       = r_q;
        err_d     = err_q;
        tgt_row_d = tgt_row_q;
        tgt_col_d = tgt_col_q;
        tgt_vld_d = tgt_vld_q;

        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_SERVE;
            ST_SERVE: if (bus.mo_fin) state_d = ST_DONE;
            ST_DONE:  if (bus.start || ld_acc) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (ld_acc && (bus.ld_sel == LD_DIMS) && !dims_bad) begin
            n_d = bus.ld_row;
            r_d = bus.ld_col;
        end

        if (start_ok) tgt_vld_d = 1'b0;
        if (read_b) begin
            tgt_row_d = bus.mo_i;
            tgt_col_d = bus.mo_j;
            tgt_vld_d = 1'b1;
        end else if (y_we) begin
            tgt_vld_d = 1'b0;
        end

        // Clear on start first so a same-cycle fault still leaves err set.
        if (start_ok) err_d = 1'b0;
        if ((ld_acc && (bus.ld_sel == LD_DIMS) && dims_bad) || ld_oob || start_bad ||
            rsp_oob || (write_y && !tgt_vld_q) || (y_we && y_woob))
            err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            r_q       <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            tgt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            r_q       <= r_d;
            err_q     <= err_d;
            rd_data_q <= y_rd;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            tgt_vld_q <= tgt_vld_d;
        end
    end

`ifdef MO_SRV_CYCLE_CNT_EN
    logic [19:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_ok)
            cyc_d = '0;
        else if (serving && (cyc_q != 20'hFFFFF))
            cyc_d = cyc_q + 20'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign bus.run_cycles = cyc_q;
`endif

    assign bus.ld_ready   = ld_ready;
    assign bus.busy       = serving;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.mo_reset   = serving;
    assign bus.mo_in_data = resp;

endmodule
